mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
Parametrised multi-cycle MIPS core, the next generation of the single-cycle processor. One 5-state FSM sequences FETCH/DECODE/EXEC/MEM/WB over a single unified memory port with a req/ready handshake, so memory can insert wait states. Adds illegal-instruction halt, a retire strobe and optional performance counters. Sits at SoC top level, attached to one memory/arbiter.

Parameters:
ADDR_W, 32, width of mem_addr; uses low ADDR_W bits of the 32-bit byte address (8..32).
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_ON_ILLEGAL, 1, 1 = illegal opcode/funct or misaligned lw/sw enters HALT; 0 = treated as NOP (retired, no state change).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  1 = write (sw), 0 = read.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data, valid when mem_ready=1.
mem_ready  in  1  completes the request in this cycle.
retire  out  1  one-cycle pulse when an instruction completes.
halted  out  1  1 while in HALT.
pc_out  out  32  current PC (debug).

Behaviour:
- Reset (rst=0, async): state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 regs=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0. mem_req is gated off while rst=0; first cycle after release asserts mem_req, addr=RESET_PC.
- Moore outputs: mem_req/mem_we/mem_addr/mem_wdata decoded from state and registers; stable while mem_req=1 and mem_ready=0. mem_ready ignored when mem_req=0.
- FETCH: mem_req=1, we=0, addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+4 (wraps at 2^32), ->DECODE; else stay.
- DECODE: A<=reg[rs], B<=reg[rt], ALUOut<=pc+(sext(imm)<<2). Unsupported opcode/funct -> HALT (or NOP/retire->FETCH if HALT_ON_ILLEGAL=0); else ->EXEC.
- Supported: R-type (op 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08. Arithmetic 32-bit modulo, no overflow trap.
- EXEC: R-type ALUOut<=A op B ->WB. addi ALUOut<=A+sext(imm) ->WB. lw/sw ALUOut<=A+sext(imm); if addr[1:0]!=0 -> HALT (or NOP), else ->MEM. beq: if A==B pc<=ALUOut; retire ->FETCH. j: pc<={pc[31:28],IR[25:0],2'b00}; retire ->FETCH.
- MEM: mem_req=1, addr=ALUOut[ADDR_W-1:0]; sw: we=1, wdata=B, on ready retire ->FETCH. lw: we=0, on ready MDR<=mem_rdata ->WB.
- WB: dest=rd (R-type) or rt (addi/lw); data=ALUOut or MDR (lw); writes to $0 discarded; retire ->FETCH.
- Zero-wait CPI: R/addi/sw 4, lw 5, beq/j 3. Each wait cycle adds 1.
- HALT: halted=1, mem_req=0, pc frozen, no retire; exits only via rst.
- Reset mid-request: request dropped immediately; memory must tolerate abandoned req.

Optional Feature:
MIPS_PERF_CNT_EN defined: adds ports cycle_cnt out 32 and instret_cnt out 32, both 0 on reset. cycle_cnt +1 every cycle out of reset except in HALT; instret_cnt +1 per retire pulse; both wrap 2^32-1 -> 0. Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
Reset release, mem_ready=1, RESET_PC=0 -> first cycle mem_req=1, addr=0, we=0; pc_out=4 the cycle after the handshake.
addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, retire at cycles 4, 8, 12 after reset.
sw $3,0x10($0) then lw $4,0x10($0), mem_ready delayed 3 cycles per access -> addr/we/wdata stable while waiting, mem word 0x10=12, $4=12, lw takes 5+6=11 cycles.
beq $1,$1,+2 at pc 0x20 -> pc=0x2C in 3 cycles; beq $1,$2 -> pc=0x24; j 0x10 -> pc=0x40.
IR=0xFC000000 (op 0x3F), HALT_ON_ILLEGAL=1 -> halted=1 after DECODE, mem_req=0 forever, no retire; rst pulse -> clean refetch from 0. lw at addr 0x11 -> halted=1.
addi $0,$0,9 -> $0 reads 0. With MIPS_PERF_CNT_EN, 3-instruction program -> instret_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mips_multicycle_core: multi-cycle MIPS subset core, one unified memory port |
// | with req/ready handshake. Optional MIPS_PERF_CNT_EN adds cycle/instret cnt. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mips_multicycle_core #(
  parameter int          ADDR_W          = 32,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       pc_out
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm_sext, ea, alu_r, wb_data;
  logic        legal, misaligned;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ea       = a_q + imm_sext;
  assign misaligned = |ea[1:0];
  assign dest     = (op == OP_RTYPE) ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_r = a_q + b_q;
    case (funct)
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_r = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    regs_d  = regs_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        alu_d = pc_q + {imm_sext[29:0], 2'b00};
        if (legal)                state_d = S_EXEC;
        else if (HALT_ON_ILLEGAL) state_d = S_HALT;
        else                      state_d = S_FETCH;
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            alu_d   = alu_r;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = ea;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d = ea;
            if (!misaligned)          state_d = S_MEM;
            else if (HALT_ON_ILLEGAL) state_d = S_HALT;
            else                      state_d = S_FETCH;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = alu_q;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = (op == OP_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        if (dest != 5'd0) regs_d[dest] = wb_data;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      regs_q  <= regs_d;
    end
  end

  // Port outputs decode from state; the rst term drops a request the moment reset asserts.
  always_comb begin
    mem_addr = '0;
    if (rst && state_q == S_FETCH)    mem_addr = pc_q[ADDR_W-1:0];
    else if (rst && state_q == S_MEM) mem_addr = alu_q[ADDR_W-1:0];
  end

  assign mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = rst && (state_q == S_MEM) && (op == OP_SW);
  assign mem_wdata = mem_we ? b_q : 32'd0;
  assign halted    = (state_q == S_HALT);
  assign pc_out    = pc_q;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE: retire = !legal && !HALT_ON_ILLEGAL;
      S_EXEC:   retire = (op == OP_BEQ) || (op == OP_J) ||
                         (((op == OP_LW) || (op == OP_SW)) && misaligned && !HALT_ON_ILLEGAL);
      S_MEM:    retire = mem_ready && (op == OP_SW);
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = (state_q == S_HALT) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    instret_cnt_d = instret_cnt_q + {31'b0, retire};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// Directed testbench for mips_multicycle_core with a wait-state memory model.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
  logic        retire, halted;
  logic [31:0] pc_out;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  logic [31:0] mem [256];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0;
  int          prog_sel = 0, wait_cfg = 0, wait_cnt = 0;
  int          hold_cmp = 0, hold_err = 0;
  bit          stall_seen = 1'b0, wr_pend = 1'b0;
  logic [31:0] sv_addr, sv_wdata, pend_addr, pend_data;
  logic        sv_we;
  int          retq[$];

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halted(halted), .pc_out(pc_out)
`ifdef MIPS_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  function automatic logic [31:0] prog_word(input int sel, input int idx);
    logic [31:0] w;
    w = 32'h0;
    case (sel)
      0: case (idx)
           0: w = 32'h2001_0005;  1: w = 32'h2002_0007;  2: w = 32'h0022_1820;
           3: w = 32'hAC03_0080;  4: w = 32'h8C04_0080;  5: w = 32'hAC04_0084;
           6: w = 32'h2000_0009;  7: w = 32'hAC00_0088;  8: w = 32'h1021_0002;
           9: w = 32'hFC00_0000; 10: w = 32'hFC00_0000; 11: w = 32'h1022_0005;
          12: w = 32'h0041_2822; 13: w = 32'h2007_FFFD; 14: w = 32'h00E1_302A;
          15: w = 32'h0022_4024; 16: w = 32'h0022_4825; 17: w = 32'hAC05_008C;
          18: w = 32'hAC06_0090; 19: w = 32'hAC08_0094; 20: w = 32'hAC09_0098;
          21: w = 32'hAC07_009C; 22: w = 32'h0800_0016; 34: w = 32'hDEAD_BEEF;
          default: w = 32'h0;
         endcase
      1: case (idx)
           0: w = 32'h2003_000C;  1: w = 32'hAC03_0080;  2: w = 32'h8C04_0080;
           3: w = 32'hAC04_0084;  4: w = 32'h0800_0004;
          default: w = 32'h0;
         endcase
      2: w = (idx == 0) ? 32'hFC00_0000 : 32'h0;
      default: w = (idx == 0) ? 32'h8C04_0011 : 32'h0;
    endcase
    return w;
  endfunction

  // Memory: reloads the selected program during reset, answers after wait_cfg stall cycles.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] = prog_word(prog_sel, i);
      mem_ready = 1'b0; wait_cnt = 0; stall_seen = 1'b0; wr_pend = 1'b0;
    end else begin
      if (wr_pend) mem[pend_addr[9:2]] = pend_data;
      wr_pend = 1'b0;
      if (!mem_req) begin
        mem_ready = 1'b0; wait_cnt = 0; stall_seen = 1'b0;
      end else begin
        if (mem_ready) wait_cnt = 0;
        if (stall_seen) begin
          hold_cmp++;
          if (mem_addr !== sv_addr || mem_we !== sv_we || mem_wdata !== sv_wdata) hold_err++;
        end
        sv_addr = mem_addr; sv_we = mem_we; sv_wdata = mem_wdata;
        if (wait_cnt >= wait_cfg) begin
          mem_ready = 1'b1; stall_seen = 1'b0;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) begin wr_pend = 1'b1; pend_addr = mem_addr; pend_data = mem_wdata; end
        end else begin
          mem_ready = 1'b0; wait_cnt++; stall_seen = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc = rst ? cyc + 1 : 1;

  always @(negedge clk) begin
    if (!rst)        retq.delete();
    else if (retire) retq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int ret_at(input int i);
    return (i < retq.size()) ? retq[i] : -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Sample in the middle of cycle n (cycle 1 = first cycle after reset release).
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    // Program A: ALU ops, $0 write, load/store, branches, jump; zero wait states.
    prog_sel = 0; wait_cfg = 0; rst = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_req",    32'(mem_req), 32'd0);
    check("rst_addr",   mem_addr, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc",     pc_out, 32'd0);
`ifdef MIPS_PERF_CNT_EN
    check("rst_cycle_cnt",   cycle_cnt, 32'd0);
    check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
    #1 rst = 1'b1;
    wait_cyc(1);
    check("c1_req",  32'(mem_req), 32'd1);
    check("c1_addr", mem_addr, 32'd0);
    check("c1_we",   32'(mem_we), 32'd0);
    wait_cyc(2);
    check("c2_pc", pc_out, 32'd4);
    wait_cyc(13);
    check("ret_addi1", 32'(ret_at(0)), 32'd4);
    check("ret_addi2", 32'(ret_at(1)), 32'd8);
    check("ret_add",   32'(ret_at(2)), 32'd12);
`ifdef MIPS_PERF_CNT_EN
    check("perf_instret", instret_cnt, 32'd3);
    check("perf_cycle",   cycle_cnt, 32'd12);
`endif
    wait_cyc(37);
    check("beq_taken_addr", mem_addr, 32'h2C);
    wait_cyc(40);
    check("beq_not_taken_addr", mem_addr, 32'h30);
    wait_cyc(83);
    check("j_addr",      mem_addr, 32'h58);
    check("j_pc",        pc_out, 32'h58);
    check("j_retire",    32'(ret_at(20)), 32'd82);
    check("retire_cnt",  32'(retq.size()), 32'd21);
    check("mem_add",     mem[32], 32'd12);
    check("mem_lw",      mem[33], 32'd12);
    check("mem_r0",      mem[34], 32'd0);
    check("mem_sub",     mem[35], 32'd2);
    check("mem_slt",     mem[36], 32'd1);
    check("mem_and",     mem[37], 32'd5);
    check("mem_or",      mem[38], 32'd7);
    check("mem_addi_neg", mem[39], 32'hFFFF_FFFD);

    // Program B: sw/lw with 3 wait states per access.
    prog_sel = 1; wait_cfg = 3;
    do_reset();
    wait_cyc(45);
    check("w_ret_addi", 32'(ret_at(0)), 32'd7);
    check("w_ret_sw",   32'(ret_at(1)), 32'd17);
    check("w_ret_lw",   32'(ret_at(2)), 32'd28);
    check("w_mem_sw",   mem[32], 32'd12);
    check("w_mem_lw",   mem[33], 32'd12);
    check("hold_seen",  32'(hold_cmp != 0), 32'd1);
    check("hold_stable", 32'(hold_err), 32'd0);

    // Reset asserted while a fetch is stalled.
    wait_cfg = 5;
    do_reset();
    wait_cyc(2);
    check("mid_req_before", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_req_dropped",  32'(mem_req), 32'd0);
    check("mid_addr_dropped", mem_addr, 32'd0);

    // Program C: illegal opcode halts.
    prog_sel = 2; wait_cfg = 0;
    do_reset();
    wait_cyc(2);
    check("ill_not_yet", 32'(halted), 32'd0);
    wait_cyc(3);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_req",    32'(mem_req), 32'd0);
    wait_cyc(25);
    check("ill_still_halted", 32'(halted), 32'd1);
    check("ill_req_late",     32'(mem_req), 32'd0);
    check("ill_no_retire",    32'(retq.size()), 32'd0);
    check("ill_pc_frozen",    pc_out, 32'd4);
`ifdef MIPS_PERF_CNT_EN
    check("ill_cycle_frozen", cycle_cnt, 32'd2);
`endif

    // Program D: reset out of halt, then misaligned lw halts.
    prog_sel = 3;
    do_reset();
    wait_cyc(1);
    check("rf_req",    32'(mem_req), 32'd1);
    check("rf_addr",   mem_addr, 32'd0);
    check("rf_halted", 32'(halted), 32'd0);
    wait_cyc(3);
    check("mis_exec", 32'(halted), 32'd0);
    wait_cyc(4);
    check("mis_halted", 32'(halted), 32'd1);
    wait_cyc(10);
    check("mis_no_retire", 32'(retq.size()), 32'd0);
    check("mis_req",       32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
